// File: rtl/thermo_enc_pipe.sv
// Two-stage thermometer-to-binary encoder with bubble detection, per-sample
// selectable bubble handling (strict / ones-count / majority) and a saturating error counter.
module thermo_enc_pipe #(
    parameter  int THERM_W   = 6,
    parameter  int ERR_CNT_W = 16,
    localparam int BIN_W     = $clog2(THERM_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    input  logic [THERM_W-1:0]   din,
    input  logic [1:0]           mode,
    input  logic                 err_cnt_clr,
    output logic                 dout_valid,
    output logic [BIN_W-1:0]     dout,
    output logic                 overrange,
    output logic                 bubble_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    function automatic logic [BIN_W-1:0] popcount(input logic [THERM_W-1:0] v);
        logic [BIN_W-1:0] cnt;
        cnt = {BIN_W{1'b0}};
        for (int i = 0; i < THERM_W; i++) begin
            cnt = cnt + BIN_W'(v[i]);
        end
        return cnt;
    endfunction

    // A legal code 2^k-1 has no set bit in common with itself plus one.
    function automatic logic is_thermo(input logic [THERM_W-1:0] v);
        logic [THERM_W-1:0] inc;
        inc = v + {{(THERM_W-1){1'b0}}, 1'b1};
        return ((v & inc) == {THERM_W{1'b0}});
    endfunction

    // Three-tap majority smoothing with an implied 1 below bit 0 and 0 above the top bit.
    function automatic logic [BIN_W-1:0] maj_encode(input logic [THERM_W-1:0] v);
        logic [THERM_W+1:0] t;
        logic [BIN_W-1:0]   pos;
        t   = {1'b0, v, 1'b1};
        pos = {BIN_W{1'b0}};
        for (int i = 0; i < THERM_W; i++) begin
            if ((t[i] & t[i+1]) | (t[i] & t[i+2]) | (t[i+1] & t[i+2])) begin
                pos = BIN_W'(i + 1);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    logic                 s1_valid_q;
    logic [THERM_W-1:0]   s1_din_q;
    logic [1:0]           s1_mode_q;
    logic                 dout_valid_q;
    logic [BIN_W-1:0]     dout_q;
    logic                 overrange_q;
    logic                 bubble_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [BIN_W-1:0]     last_good_q;

    logic                 legal_s;
    logic [BIN_W-1:0]     ones_s;
    logic [BIN_W-1:0]     enc_d;
    logic                 ovr_d;
    logic                 bub_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    // Stage 1: capture the raw sample and its mode every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_din_q   <= {THERM_W{1'b0}};
            s1_mode_q  <= 2'd0;
        end else begin
            s1_valid_q <= din_valid;
            s1_din_q   <= din;
            s1_mode_q  <= mode;
        end
    end

    // Encode the stage-1 sample according to its captured mode.
    always_comb begin
        legal_s = is_thermo(s1_din_q);
        ones_s  = popcount(s1_din_q);
        enc_d   = ones_s;
        if (legal_s) begin
            enc_d = ones_s;
        end else begin
            case (s1_mode_q)
                2'd1:    enc_d = ones_s;
                2'd2:    enc_d = maj_encode(s1_din_q);
                default: enc_d = last_good_q;
            endcase
        end
        bub_d = ~legal_s;
        ovr_d = (s1_din_q == {THERM_W{1'b1}});
    end

    // Error counter next state: clear wins over a saturating increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = {ERR_CNT_W{1'b0}};
        end else if (s1_valid_q && !legal_s && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1'b1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Stage 2: result registers hold their value across idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_q <= 1'b0;
            dout_q       <= {BIN_W{1'b0}};
            overrange_q  <= 1'b0;
            bubble_err_q <= 1'b0;
            last_good_q  <= {BIN_W{1'b0}};
            err_cnt_q    <= {ERR_CNT_W{1'b0}};
        end else begin
            dout_valid_q <= s1_valid_q;
            err_cnt_q    <= err_cnt_d;
            if (s1_valid_q) begin
                dout_q       <= enc_d;
                overrange_q  <= ovr_d;
                bubble_err_q <= bub_d;
            end
            if (s1_valid_q && legal_s) begin
                last_good_q <= ones_s;
            end
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign overrange  = overrange_q;
    assign bubble_err = bubble_err_q;
    assign err_cnt    = err_cnt_q;

endmodule
